dec_stage_pipe: RTL and testbench

- Parametrised next-generation decode stage for the five-stage MIPS pipeline, sitting between fetch and execute.
- Combines instruction decode, an NREGS x DATA_W register file with write-through bypass, and a registered ID/EX output.
- Adds valid/stall handshaking, load-use interlock and branch flush, which the single-cycle decode does not have.

---
 rtl/dec_stage_pipe_pkg.sv | 52 +++++
 rtl/dec_stage_pipe_decoder.sv | 93 +++++++++
 rtl/dec_stage_pipe_regfile.sv | 44 ++++
 rtl/dec_stage_pipe.sv | 162 ++++++++++++++++
 tb/tb_dec_stage_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dec_stage_pipe_pkg.sv
// Shared decode types: control bundle, opcode and RegDst encodings, operand-use helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dec_pkg;

    typedef struct packed {
        logic       Branch;
        logic       Jump;
        logic       MemRead;
        logic       MemtoReg;
        logic [2:0] ALUOp;
        logic       MULOp;
        logic       MemWrite;
        logic       ALUSrc;
        logic       BRASrc;
        logic       RegWrite;
    } dec_ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // Destination select: 00 = rt, 01 = rd, 1x = link register
    localparam logic [1:0] RD_RT   = 2'b00;
    localparam logic [1:0] RD_RD   = 2'b01;
    localparam logic [1:0] RD_LINK = 2'b10;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_RTYPE = 3'd2;
    localparam logic [2:0] ALU_SLT   = 3'd3;
    localparam logic [2:0] ALU_AND   = 3'd4;
    localparam logic [2:0] ALU_OR    = 3'd5;
    localparam logic [2:0] ALU_XOR   = 3'd6;
    localparam logic [2:0] ALU_LUI   = 3'd7;

    // Rt is a real source only for R-type, compare-branches and stores
    function automatic logic uses_rt(input logic [5:0] opcode, input dec_ctrl_t ctrl);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) || ctrl.MemWrite;
    endfunction

endpackage

// File: rtl/dec_stage_pipe_decoder.sv
// Combinational MIPS instruction decoder: control bundle, immediate, register fields.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the instruction word.
module dec_decoder
    import dec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       instr,
    output dec_ctrl_t         ctrl,
    output logic [1:0]        reg_dst,
    output logic [DATA_W-1:0] imm,
    output logic [5:0]        alu_func,
    output logic [2:0]        mem_func,
    output logic [4:0]        shamt,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd
);

    logic [5:0] opcode;

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign alu_func = instr[5:0];

    // Opcode table; loads are 0x20-0x27, stores 0x28-0x2F, memfunc is the low opcode bits
    always_comb begin
        ctrl     = '0;
        reg_dst  = RD_RT;
        imm      = DATA_W'($signed(instr[15:0]));
        mem_func = 3'd0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.RegWrite = 1'b1;
                ctrl.ALUOp    = ALU_RTYPE;
                ctrl.MULOp    = (instr[5:2] == 4'b0110);
                reg_dst       = RD_RD;
            end
            OP_J: begin
                ctrl.Jump = 1'b1;
                imm       = DATA_W'(instr[25:0]);
            end
            OP_JAL: begin
                ctrl.Jump     = 1'b1;
                ctrl.RegWrite = 1'b1;
                reg_dst       = RD_LINK;
                imm           = DATA_W'(instr[25:0]);
            end
            OP_BEQ, OP_BNE: begin
                ctrl.Branch = 1'b1;
                ctrl.ALUOp  = ALU_SUB;
                ctrl.BRASrc = (opcode == OP_BNE);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                ctrl.ALUSrc   = 1'b1;
                ctrl.RegWrite = 1'b1;
                ctrl.ALUOp    = opcode[1] ? ALU_SLT : ALU_ADD;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.ALUSrc   = 1'b1;
                ctrl.RegWrite = 1'b1;
                ctrl.ALUOp    = (opcode == OP_ANDI) ? ALU_AND : (opcode == OP_ORI) ? ALU_OR : ALU_XOR;
                imm           = DATA_W'(instr[15:0]);
            end
            OP_LUI: begin
                ctrl.ALUSrc   = 1'b1;
                ctrl.RegWrite = 1'b1;
                ctrl.ALUOp    = ALU_LUI;
                imm           = DATA_W'($signed({instr[15:0], 16'h0000}));
            end
            default: begin
                if (opcode[5:3] == 3'b100) begin
                    ctrl.MemRead  = 1'b1;
                    ctrl.MemtoReg = 1'b1;
                    ctrl.RegWrite = 1'b1;
                    ctrl.ALUSrc   = 1'b1;
                    ctrl.ALUOp    = ALU_ADD;
                    mem_func      = opcode[2:0];
                end else if (opcode[5:3] == 3'b101) begin
                    ctrl.MemWrite = 1'b1;
                    ctrl.ALUSrc   = 1'b1;
                    ctrl.ALUOp    = ALU_ADD;
                    mem_func      = opcode[2:0];
                end
            end
        endcase
    end

endmodule

// File: rtl/dec_stage_pipe_regfile.sv
// Register file with hardwired zero register and same-cycle write-to-read bypass.
// Latency: reads 0 cycles, writes visible to reads in the same cycle via bypass.
// Backpressure: none; writes are always accepted.
module regfile_bypass #(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 32,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              core_clk,
    input  logic              arst_n,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_dat,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_dat,
    input  logic              wr_vld,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_en;

    assign wr_en = wr_vld && (wr_addr != '0);

    // Storage; register 0 is never written so it stays at its reset value of zero
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_dat;
        end
    end

    // Read ports: zero register first, then bypass from the writeback in flight
    always_comb begin
        rd0_dat = regs[rd0_addr];
        rd1_dat = regs[rd1_addr];
        if (rd0_addr == '0)                     rd0_dat = '0;
        else if (wr_en && wr_addr == rd0_addr)  rd0_dat = wr_dat;
        if (rd1_addr == '0)                     rd1_dat = '0;
        else if (wr_en && wr_addr == rd1_addr)  rd1_dat = wr_dat;
    end

endmodule

// File: rtl/dec_stage_pipe.sv
// Decode stage: decoder + bypassed regfile + ID/EX register with stall/flush handling.
// Latency: 1 cycle from accepted fetch input to ID/EX outputs.
// Backpressure: ExStall holds ID/EX; InStall (comb) holds fetch on ExStall or load-use.
module dec_stage_pipe
    import dec_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int NREGS    = 32,
    parameter  int LINK_REG = NREGS - 1,
    localparam int ADDR_W   = $clog2(NREGS)
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic [31:0]       Instruction,
    input  logic [31:0]       InstrAddrIn,
    input  logic              InValid,
    output logic              InStall,
    input  logic              ExStall,
    input  logic              Flush,
    input  logic              RegWriteIn,
    input  logic [ADDR_W-1:0] RegAddr,
    input  logic [DATA_W-1:0] RData,
    output logic              OutValid,
    output dec_ctrl_t         Ctrl,
    output logic [5:0]        ALUfunc,
    output logic [2:0]        Memfunc,
    output logic [4:0]        Shamt,
    output logic [DATA_W-1:0] ImmData,
    output logic [DATA_W-1:0] RsData,
    output logic [DATA_W-1:0] RtData,
    output logic [ADDR_W-1:0] RsAddr,
    output logic [ADDR_W-1:0] RtAddr,
    output logic [ADDR_W-1:0] RAddrOut,
    output logic [31:0]       InstrAddrOut
);

    typedef struct packed {
        logic              valid;
        dec_ctrl_t         ctrl;
        logic [5:0]        alu_func;
        logic [2:0]        mem_func;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] rs_dat;
        logic [DATA_W-1:0] rt_dat;
        logic [ADDR_W-1:0] rs_addr;
        logic [ADDR_W-1:0] rt_addr;
        logic [ADDR_W-1:0] rd_addr;
        logic [31:0]       pc;
    } idex_t;

    dec_ctrl_t         dec_ctrl;
    logic [1:0]        dec_reg_dst;
    logic [DATA_W-1:0] dec_imm;
    logic [5:0]        dec_alu_func;
    logic [2:0]        dec_mem_func;
    logic [4:0]        dec_shamt;
    logic [4:0]        dec_rs;
    logic [4:0]        dec_rt;
    logic [4:0]        dec_rd;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] rs_dat;
    logic [DATA_W-1:0] rt_dat;
    logic              load_use;
    idex_t             dec_word;
    idex_t             idex_d;
    idex_t             idex_q;

    dec_decoder #(.DATA_W(DATA_W)) u_dec (
        .instr    (Instruction),
        .ctrl     (dec_ctrl),
        .reg_dst  (dec_reg_dst),
        .imm      (dec_imm),
        .alu_func (dec_alu_func),
        .mem_func (dec_mem_func),
        .shamt    (dec_shamt),
        .rs       (dec_rs),
        .rt       (dec_rt),
        .rd       (dec_rd)
    );

    // Instruction fields are 5 bits; fit them to the configured register count
    assign rs_addr = ADDR_W'(dec_rs);
    assign rt_addr = ADDR_W'(dec_rt);

    regfile_bypass #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .core_clk (Clock),
        .arst_n   (nReset),
        .rd0_addr (rs_addr),
        .rd0_dat  (rs_dat),
        .rd1_addr (rt_addr),
        .rd1_dat  (rt_dat),
        .wr_vld   (RegWriteIn),
        .wr_addr  (RegAddr),
        .wr_dat   (RData)
    );

    // Destination register select
    always_comb begin
        case (dec_reg_dst)
            RD_RT:   dst_addr = rt_addr;
            RD_RD:   dst_addr = ADDR_W'(dec_rd);
            default: dst_addr = ADDR_W'(LINK_REG);
        endcase
    end

    // A load in ID/EX whose result is a source of the incoming instruction cannot be forwarded in time
    assign load_use = InValid && idex_q.valid && idex_q.ctrl.MemRead && (idex_q.rd_addr != '0)
                      && ((idex_q.rd_addr == rs_addr)
                          || (uses_rt(Instruction[31:26], dec_ctrl) && (idex_q.rd_addr == rt_addr)));

    // Flush discards the fetch word, so it never asks fetch to hold
    assign InStall = nReset && !Flush && (ExStall || load_use);

    // Assemble the decoded ID/EX word for the current fetch input
    always_comb begin
        dec_word          = '0;
        dec_word.valid    = 1'b1;
        dec_word.ctrl     = dec_ctrl;
        dec_word.alu_func = dec_alu_func;
        dec_word.mem_func = dec_mem_func;
        dec_word.shamt    = dec_shamt;
        dec_word.imm      = dec_imm;
        dec_word.rs_dat   = rs_dat;
        dec_word.rt_dat   = rt_dat;
        dec_word.rs_addr  = rs_addr;
        dec_word.rt_addr  = rt_addr;
        dec_word.rd_addr  = dst_addr;
        dec_word.pc       = InstrAddrIn;
    end

    // Next ID/EX: flush > execute stall (hold) > load-use bubble > load or bubble
    always_comb begin
        idex_d = '0;
        if (!Flush) begin
            if (ExStall)                    idex_d = idex_q;
            else if (!load_use && InValid)  idex_d = dec_word;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) idex_q <= '0;
        else         idex_q <= idex_d;
    end

    assign OutValid     = idex_q.valid;
    assign Ctrl         = idex_q.ctrl;
    assign ALUfunc      = idex_q.alu_func;
    assign Memfunc      = idex_q.mem_func;
    assign Shamt        = idex_q.shamt;
    assign ImmData      = idex_q.imm;
    assign RsData       = idex_q.rs_dat;
    assign RtData       = idex_q.rt_dat;
    assign RsAddr       = idex_q.rs_addr;
    assign RtAddr       = idex_q.rt_addr;
    assign RAddrOut     = idex_q.rd_addr;
    assign InstrAddrOut = idex_q.pc;

endmodule

// File: tb/tb_dec_stage_pipe.sv
module tb_dec_stage_pipe;
    import dec_pkg::*;

    localparam int DW = 64;
    localparam int NR = 64;
    localparam int AW = 6;

    logic          Clock;
    logic          nReset;
    logic [31:0]   Instruction;
    logic [31:0]   InstrAddrIn;
    logic          InValid;
    logic          InStall;
    logic          ExStall;
    logic          Flush;
    logic          RegWriteIn;
    logic [AW-1:0] RegAddr;
    logic [DW-1:0] RData;
    logic          OutValid;
    dec_ctrl_t     Ctrl;
    logic [5:0]    ALUfunc;
    logic [2:0]    Memfunc;
    logic [4:0]    Shamt;
    logic [DW-1:0] ImmData;
    logic [DW-1:0] RsData;
    logic [DW-1:0] RtData;
    logic [AW-1:0] RsAddr;
    logic [AW-1:0] RtAddr;
    logic [AW-1:0] RAddrOut;
    logic [31:0]   InstrAddrOut;

    dec_stage_pipe #(.DATA_W(DW), .NREGS(NR)) dut (
        .Clock(Clock), .nReset(nReset), .Instruction(Instruction), .InstrAddrIn(InstrAddrIn),
        .InValid(InValid), .InStall(InStall), .ExStall(ExStall), .Flush(Flush),
        .RegWriteIn(RegWriteIn), .RegAddr(RegAddr), .RData(RData), .OutValid(OutValid),
        .Ctrl(Ctrl), .ALUfunc(ALUfunc), .Memfunc(Memfunc), .Shamt(Shamt), .ImmData(ImmData),
        .RsData(RsData), .RtData(RtData), .RsAddr(RsAddr), .RtAddr(RtAddr),
        .RAddrOut(RAddrOut), .InstrAddrOut(InstrAddrOut)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Reference model state: what the ID/EX register must hold, plus architectural registers
    typedef struct packed {
        logic        ov;
        dec_ctrl_t   ctrl;
        logic [5:0]  af;
        logic [2:0]  mf;
        logic [4:0]  sh;
        logic [63:0] imm;
        logic [63:0] rsd;
        logic [63:0] rtd;
        logic [5:0]  rsa;
        logic [5:0]  rta;
        logic [5:0]  rda;
        logic [31:0] pc;
    } mst_t;

    mst_t        m;
    mst_t        nx;
    logic [63:0] mrf [NR];
    logic        exp_install;
    logic        p_rst;
    logic        p_wr;
    logic [5:0]  p_wa;
    logic [63:0] p_wd;
    int          n_vec;
    int          n_bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Decode straight from the opcode classes of the MIPS ISA subset
    function automatic void mdec(input logic [31:0] ins, output dec_ctrl_t c, output logic [63:0] imm,
                                 output logic [5:0] dst, output logic [2:0] mf, output logic urt);
        logic [5:0] op;
        op  = ins[31:26];
        c   = '0;
        imm = {{48{ins[15]}}, ins[15:0]};
        dst = {1'b0, ins[20:16]};
        mf  = 3'd0;
        urt = 1'b0;
        if (op == 6'd0) begin
            c.RegWrite = 1'b1; c.ALUOp = 3'd2; dst = {1'b0, ins[15:11]}; urt = 1'b1;
            c.MULOp = (ins[5:0] >= 6'd24) && (ins[5:0] <= 6'd27);
        end else if (op == 6'd2) begin
            c.Jump = 1'b1; imm = {38'd0, ins[25:0]};
        end else if (op == 6'd3) begin
            c.Jump = 1'b1; c.RegWrite = 1'b1; dst = 6'd63; imm = {38'd0, ins[25:0]};
        end else if (op == 6'd4 || op == 6'd5) begin
            c.Branch = 1'b1; c.ALUOp = 3'd1; c.BRASrc = (op == 6'd5); urt = 1'b1;
        end else if (op >= 6'd8 && op <= 6'd15) begin
            c.ALUSrc = 1'b1; c.RegWrite = 1'b1;
            if (op <= 6'd9)       c.ALUOp = 3'd0;
            else if (op <= 6'd11) c.ALUOp = 3'd3;
            else if (op == 6'd15) begin c.ALUOp = 3'd7; imm = {{32{ins[15]}}, ins[15:0], 16'h0}; end
            else begin c.ALUOp = 3'(op - 6'd8); imm = {48'd0, ins[15:0]}; end
        end else if (op >= 6'd32 && op <= 6'd39) begin
            c.MemRead = 1'b1; c.MemtoReg = 1'b1; c.RegWrite = 1'b1; c.ALUSrc = 1'b1; mf = op[2:0];
        end else if (op >= 6'd40 && op <= 6'd47) begin
            c.MemWrite = 1'b1; c.ALUSrc = 1'b1; mf = op[2:0]; urt = 1'b1;
        end
    endfunction

    function automatic logic [63:0] rdv(input logic [5:0] a);
        if (a == 6'd0) return 64'd0;
        if (RegWriteIn && RegAddr == a) return RData;
        return mrf[a];
    endfunction

    task automatic model_eval();
        dec_ctrl_t   c;
        logic [63:0] imm;
        logic [5:0]  dst;
        logic [5:0]  rs;
        logic [5:0]  rt;
        logic [2:0]  mf;
        logic        urt;
        logic        hz;
        mst_t        d;
        p_rst = !nReset;
        p_wr  = RegWriteIn && RegAddr != 6'd0;
        p_wa  = RegAddr;
        p_wd  = RData;
        nx    = '0;
        exp_install = 1'b0;
        if (!nReset) return;
        mdec(Instruction, c, imm, dst, mf, urt);
        rs = {1'b0, Instruction[25:21]};
        rt = {1'b0, Instruction[20:16]};
        hz = InValid && m.ov && m.ctrl.MemRead && m.rda != 6'd0 && (m.rda == rs || (urt && m.rda == rt));
        exp_install = !Flush && (ExStall || hz);
        d = '{ov: 1'b1, ctrl: c, af: Instruction[5:0], mf: mf, sh: Instruction[10:6], imm: imm,
              rsd: rdv(rs), rtd: rdv(rt), rsa: rs, rta: rt, rda: dst, pc: InstrAddrIn};
        if (Flush)        nx = '0;
        else if (ExStall) nx = m;
        else if (hz)      nx = '0;
        else if (InValid) nx = d;
    endtask

    task automatic model_commit();
        m = nx;
        if (p_rst) begin
            for (int i = 0; i < NR; i++) mrf[i] = 64'd0;
        end else if (p_wr) begin
            mrf[p_wa] = p_wd;
        end
    endtask

    task automatic compare();
        chk("InStall", 64'(InStall), 64'(exp_install));
        chk("OutValid", 64'(OutValid), 64'(m.ov));
        chk("Ctrl", 64'(Ctrl), 64'(m.ctrl));
        chk("ALUfunc", 64'(ALUfunc), 64'(m.af));
        chk("Memfunc", 64'(Memfunc), 64'(m.mf));
        chk("Shamt", 64'(Shamt), 64'(m.sh));
        chk("ImmData", ImmData, m.imm);
        chk("RsData", RsData, m.rsd);
        chk("RtData", RtData, m.rtd);
        chk("RsAddr", 64'(RsAddr), 64'(m.rsa));
        chk("RtAddr", 64'(RtAddr), 64'(m.rta));
        chk("RAddrOut", 64'(RAddrOut), 64'(m.rda));
        chk("InstrAddrOut", 64'(InstrAddrOut), 64'(m.pc));
    endtask

    // One clock: check at the falling edge, advance the model just after the rising edge
    task automatic cycle();
        @(negedge Clock);
        model_eval();
        compare();
        @(posedge Clock);
        #1;
        model_commit();
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic vld);
        Instruction = ins;
        InstrAddrIn = pc;
        InValid     = vld;
        Flush       = 1'b0;
        ExStall     = 1'b0;
        RegWriteIn  = 1'b0;
        RegAddr     = '0;
        RData       = '0;
    endtask

    logic [5:0]  ops [18];
    logic [5:0]  op;
    logic [31:0] pc;
    logic        held;

    initial begin
        n_vec = 0;
        n_bad = 0;
        m = '0;
        nx = '0;
        exp_install = 1'b0;
        for (int i = 0; i < NR; i++) mrf[i] = 64'd0;
        nReset = 1'b0;
        drive(32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_OutValid", 64'(OutValid), 64'd0);
        chk("rst_InStall", 64'(InStall), 64'd0);
        chk("rst_Ctrl", 64'(Ctrl), 64'd0);
        chk("rst_ImmData", ImmData, 64'd0);
        nReset = 1'b1;

        // ADDI r1,r0,5
        drive(32'h20010005, 32'h0000_0104, 1'b1);
        cycle();
        chk("addi_OutValid", 64'(OutValid), 64'd1);
        chk("addi_ImmData", ImmData, 64'd5);
        chk("addi_RAddrOut", 64'(RAddrOut), 64'd1);
        chk("addi_RegWrite", 64'(Ctrl.RegWrite), 64'd1);
        chk("addi_ALUSrc", 64'(Ctrl.ALUSrc), 64'd1);
        chk("addi_InstrAddrOut", 64'(InstrAddrOut), 64'h104);

        // ADD r4,r3,r0 while r3 is written back
        drive(32'h00602020, 32'h108, 1'b1);
        RegWriteIn = 1'b1; RegAddr = 6'd3; RData = 64'hDEADBEEF;
        cycle();
        chk("bypass_RsData", RsData, 64'hDEADBEEF);
        drive(32'h00002020, 32'h10C, 1'b1);
        RegWriteIn = 1'b1; RegAddr = 6'd0; RData = 64'h1234;
        cycle();
        chk("r0_RsData", RsData, 64'd0);
        chk("r0_RtData", RtData, 64'd0);

        // LW r2,0(r1) then ADD r5,r2,r2
        drive(32'h8C220000, 32'h110, 1'b1);
        cycle();
        drive(32'h00422820, 32'h114, 1'b1);
        #1;
        chk("lu_InStall", 64'(InStall), 64'd1);
        cycle();
        chk("lu_bubble_OutValid", 64'(OutValid), 64'd0);
        chk("lu_bubble_Ctrl", 64'(Ctrl), 64'd0);
        #1;
        chk("lu_InStall_release", 64'(InStall), 64'd0);
        cycle();
        chk("lu_add_OutValid", 64'(OutValid), 64'd1);
        chk("lu_add_RsAddr", 64'(RsAddr), 64'd2);
        chk("lu_add_RtAddr", 64'(RtAddr), 64'd2);
        drive(32'h0, 32'h0, 1'b0);
        cycle();
        chk("lu_add_once", 64'(OutValid), 64'd0);

        // LW r0 then ADD using r0: no interlock
        drive(32'h8C200000, 32'h120, 1'b1);
        cycle();
        drive(32'h00002820, 32'h124, 1'b1);
        #1;
        chk("lu_r0_InStall", 64'(InStall), 64'd0);
        cycle();
        chk("lu_r0_OutValid", 64'(OutValid), 64'd1);

        // Execute stall for three cycles
        drive(32'h20010005, 32'h200, 1'b1);
        cycle();
        drive(32'h340600FF, 32'h204, 1'b1);
        ExStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("exs_InStall", 64'(InStall), 64'd1);
            cycle();
            chk("exs_hold_ImmData", ImmData, 64'd5);
            chk("exs_hold_pc", 64'(InstrAddrOut), 64'h200);
        end
        ExStall = 1'b0;
        cycle();
        chk("exs_rel_ImmData", ImmData, 64'hFF);
        chk("exs_rel_pc", 64'(InstrAddrOut), 64'h204);
        drive(32'h0, 32'h0, 1'b0);
        cycle();
        chk("exs_no_dup", 64'(OutValid), 64'd0);

        // Flush beats execute stall and load-use
        drive(32'h8C220000, 32'h2F0, 1'b1);
        cycle();
        drive(32'h00422820, 32'h2F4, 1'b1);
        Flush = 1'b1; ExStall = 1'b1;
        #1;
        chk("flush_InStall", 64'(InStall), 64'd0);
        cycle();
        chk("flush_OutValid", 64'(OutValid), 64'd0);
        drive(32'h20010005, 32'h300, 1'b1);
        cycle();
        chk("post_flush_OutValid", 64'(OutValid), 64'd1);
        chk("post_flush_ImmData", ImmData, 64'd5);

        // JAL and LUI immediates at 64-bit width
        drive(32'h0C000040, 32'h400, 1'b1);
        cycle();
        chk("jal_RAddrOut", 64'(RAddrOut), 64'd63);
        chk("jal_ImmData", ImmData, 64'h40);
        chk("jal_Jump", 64'(Ctrl.Jump), 64'd1);
        drive(32'h3C018000, 32'h404, 1'b1);
        cycle();
        chk("lui_ImmData", ImmData, 64'hFFFF_FFFF_8000_0000);

        // Reset asserted in the middle of an execute stall
        drive(32'h20010005, 32'h500, 1'b1);
        cycle();
        drive(32'h340600FF, 32'h504, 1'b1);
        ExStall = 1'b1;
        cycle();
        nReset = 1'b0;
        #1;
        chk("arst_OutValid", 64'(OutValid), 64'd0);
        chk("arst_InStall", 64'(InStall), 64'd0);
        chk("arst_ImmData", ImmData, 64'd0);
        m = '0;
        for (int i = 0; i < NR; i++) mrf[i] = 64'd0;
        cycle();
        nReset = 1'b1;
        drive(32'h00602020, 32'h600, 1'b1);
        cycle();
        chk("arst_rel_OutValid", 64'(OutValid), 64'd1);
        chk("arst_rel_RsData", RsData, 64'd0);

        // Randomised traffic with a fetch unit that honours InStall
        ops = '{6'd0, 6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10,
                6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd32, 6'd43, 6'd41};
        pc   = 32'h1000;
        held = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (!held) begin
                op = ops[$urandom_range(0, 17)];
                if ($urandom_range(0, 9) == 0) op = 6'($urandom);
                Instruction = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                               5'($urandom_range(0, 7)), 11'($urandom)};
                pc = pc + 32'd4;
                InstrAddrIn = pc;
                InValid = ($urandom_range(0, 9) < 8);
            end
            Flush      = ($urandom_range(0, 19) == 0);
            ExStall    = ($urandom_range(0, 9) == 0);
            RegWriteIn = ($urandom_range(0, 1) == 1);
            RegAddr    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
            RData      = {$urandom, $urandom};
            cycle();
            held = exp_install;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
